// File: rtl/io_port_ctrl_pkg.sv
// Shared definitions for the I/O port sequencer: state encoding, default
// device-wait timeout, and a helper that identifies the device-wait states.
package io_port_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OUT_LD  = 3'd1,
    OUT_STB = 3'd2,
    OUT_REL = 3'd3,
    IN_WAIT = 3'd4,
    IN_LD   = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  // States in which the sequencer waits on the device and can time out.
  function automatic logic is_wait_state(input state_e s);
    return (s == OUT_STB) || (s == OUT_REL) || (s == IN_WAIT);
  endfunction

endpackage

// File: rtl/io_timeout_timer.sv
// Device-wait timeout timer.
//   clock, clear : clock and asynchronous active-high reset
//   restart      : zero the count (asserted on every state change)
//   enable       : count one cycle spent in a wait state
//   tc           : count has reached TIMEOUT-1 while enabled (never if TIMEOUT=0)
module io_timeout_timer
  import io_port_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (TIMEOUT != 0) && enable && (count_q == TC_VAL);

endmodule

// File: rtl/io_port_ctrl.sv
// I/O transfer sequencer between the control unit, the in/out port
// registers and the device pins.
//   clock, clear        : clock and asynchronous active-high reset
//   cpu_req/cpu_rw      : request pulse (sampled in IDLE), 1 = output, 0 = input
//   cpu_err_clr         : clears err_sticky (a coincident timeout wins)
//   cpu_busy/done/err   : status; done pulses on completion, err with it on timeout
//   err_sticky          : latched timeout indication
//   out_port_ld/in_port_ld : port register load strobes
//   dev_strobe/dev_ack  : four-phase output handshake
//   dev_rd_req/dev_valid: input handshake
//   xfer_count          : successful transfers, wrapping
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             cpu_req,
  input  logic             cpu_rw,
  input  logic             cpu_err_clr,
  output logic             cpu_busy,
  output logic             cpu_done,
  output logic             cpu_err,
  output logic             err_sticky,
  output logic             out_port_ld,
  output logic             in_port_ld,
  output logic             dev_strobe,
  input  logic             dev_ack,
  output logic             dev_rd_req,
  input  logic             dev_valid,
  output logic [CNT_W-1:0] xfer_count
);

  state_e state_q, state_d;
  logic   tmo_tc;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic out_ld_q, out_ld_d;
  logic in_ld_q, in_ld_d;
  logic strobe_q, strobe_d;
  logic rd_req_q, rd_req_d;
  logic err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

  io_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .clear   (clear),
    .restart (state_d != state_q),
    .enable  (is_wait_state(state_q)),
    .tc      (tmo_tc)
  );

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a device exit condition always takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = cpu_rw ? OUT_LD : IN_WAIT;
      OUT_LD:  state_d = OUT_STB;
      OUT_STB: begin
        if (dev_ack)     state_d = OUT_REL;
        else if (tmo_tc) state_d = ERR;
      end
      OUT_REL: begin
        if (!dev_ack)    state_d = DONE;
        else if (tmo_tc) state_d = ERR;
      end
      IN_WAIT: begin
        if (dev_valid)   state_d = IN_LD;
        else if (tmo_tc) state_d = ERR;
      end
      IN_LD:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so each output
  // lines up with its state while remaining a clean flop output.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE) || (state_d == ERR);
    err_d    = (state_d == ERR);
    out_ld_d = (state_d == OUT_LD);
    in_ld_d  = (state_d == IN_LD);
    strobe_d = (state_d == OUT_STB);
    rd_req_d = (state_d == IN_WAIT);

    err_sticky_d = err_sticky_q;
    if (state_q == ERR) begin
      err_sticky_d = 1'b1;
    end else if (cpu_err_clr) begin
      err_sticky_d = 1'b0;
    end

    xfer_count_d = xfer_count_q;
    if (state_q == DONE) begin
      xfer_count_d = xfer_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      out_ld_q     <= 1'b0;
      in_ld_q      <= 1'b0;
      strobe_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      err_sticky_q <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      out_ld_q     <= out_ld_d;
      in_ld_q      <= in_ld_d;
      strobe_q     <= strobe_d;
      rd_req_q     <= rd_req_d;
      err_sticky_q <= err_sticky_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign cpu_busy    = busy_q;
  assign cpu_done    = done_q;
  assign cpu_err     = err_q;
  assign err_sticky  = err_sticky_q;
  assign out_port_ld = out_ld_q;
  assign in_port_ld  = in_ld_q;
  assign dev_strobe  = strobe_q;
  assign dev_rd_req  = rd_req_q;
  assign xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

  localparam int T  = 8;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic clear, cpu_req, cpu_rw, cpu_err_clr, dev_ack, dev_valid;
  logic cpu_busy, cpu_done, cpu_err, err_sticky;
  logic out_port_ld, in_port_ld, dev_strobe, dev_rd_req;
  logic [CW-1:0] xfer_count;

  io_port_ctrl #(
    .TIMEOUT (T),
    .CNT_W   (CW)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_err_clr (cpu_err_clr),
    .cpu_busy    (cpu_busy),
    .cpu_done    (cpu_done),
    .cpu_err     (cpu_err),
    .err_sticky  (err_sticky),
    .out_port_ld (out_port_ld),
    .in_port_ld  (in_port_ld),
    .dev_strobe  (dev_strobe),
    .dev_ack     (dev_ack),
    .dev_rd_req  (dev_rd_req),
    .dev_valid   (dev_valid),
    .xfer_count  (xfer_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic          sticky;
    logic          out_ld;
    logic          in_ld;
    logic          strobe;
    logic          rd_req;
    logic [CW-1:0] count;
  } obs_t;

  typedef struct {
    logic  rw;
    int    d1;       // cycles of wait before ack/valid appears
    int    d2;       // extra cycles ack is held after entering release
    int    exp_done; // cycle of cpu_done counted from the request edge
    logic  exp_err;
    string name;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   m_count = 0;     // reference: successful transfers mod 2^CW
  logic m_sticky = 1'b0; // reference: latched error

  function automatic obs_t sample();
    return {cpu_busy, cpu_done, cpu_err, err_sticky, out_port_ld, in_port_ld,
            dev_strobe, dev_rd_req, xfer_count};
  endfunction

  task automatic check_obs(input string name, input int c, input obs_t exp);
    obs_t act;
    act = sample();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s c=%0d: got %b want %b (busy,done,err,sticky,oldd,ild,stb,rdq,count)",
               name, c, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level timing rules: the whole transfer is summarised by when
  // the device responds relative to the timeout window.
  function automatic logic txn_err(input logic rw, input int d1, input int d2);
    if (d1 >= T) return 1'b1;
    return rw && (d2 >= T);
  endfunction

  function automatic int done_cycle(input logic rw, input int d1, input int d2);
    if (rw) begin
      if (d1 >= T) return T + 2;
      if (d2 >= T) return 3 + d1 + T;
      return 4 + d1 + d2;
    end
    if (d1 >= T) return T + 1;
    return 3 + d1;
  endfunction

  function automatic obs_t exp_at(input logic rw, input int d1, input int d2, input int c);
    obs_t e;
    int   dc;
    int   stb_end;
    int   rd_end;
    dc = done_cycle(rw, d1, d2);
    stb_end = (d1 >= T) ? T + 1 : 2 + d1;
    rd_end  = (d1 >= T) ? T : 1 + d1;
    e = '0;
    e.busy   = (c >= 1) && (c <= dc);
    e.done   = (c == dc);
    e.err    = (c == dc) && txn_err(rw, d1, d2);
    e.out_ld = rw && (c == 1);
    e.in_ld  = !rw && (d1 < T) && (c == 2 + d1);
    e.strobe = rw && (c >= 2) && (c <= stb_end);
    e.rd_req = !rw && (c >= 1) && (c <= rd_end);
    e.sticky = m_sticky;
    e.count  = CW'(m_count);
    return e;
  endfunction

  // Runs one transfer starting from an idle cycle; leaves the bench on the
  // idle cycle after completion, already checked.
  task automatic run_txn(input logic rw, input int d1, input int d2, input bit noise,
                         input string tag, output int obs_done, output logic obs_err);
    int   dc;
    logic er;
    logic clr;
    obs_t e;
    dc = done_cycle(rw, d1, d2);
    er = txn_err(rw, d1, d2);
    obs_done = 0;
    obs_err  = 1'b0;
    cpu_req = 1'b1;
    cpu_rw  = rw;
    clr = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    cpu_err_clr = clr;
    dev_ack = 1'b0;
    dev_valid = 1'b0;
    if (clr) m_sticky = 1'b0;
    step();
    for (int c = 1; c <= dc + 1; c++) begin
      e = exp_at(rw, d1, d2, c);
      check_obs(tag, c, e);
      if (cpu_done === 1'b1 && obs_done == 0) begin
        obs_done = c;
        obs_err  = cpu_err;
      end
      if (c <= dc) begin
        cpu_req = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
        cpu_rw  = 1'($urandom_range(0, 1));
        clr = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        cpu_err_clr = clr;
        dev_ack   = rw && (c >= 2 + d1) && (c < 3 + d1 + d2);
        dev_valid = !rw && (c >= 1 + d1);
        if (c == dc && er) m_sticky = 1'b1;
        else if (clr)      m_sticky = 1'b0;
        if (c == dc && !er) m_count = (m_count + 1) % (1 << CW);
        step();
      end
    end
    cpu_req = 1'b0;
    cpu_err_clr = 1'b0;
    dev_ack = 1'b0;
    dev_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int   od;
    logic oe;

    vecs[0] = '{1'b1, 2, 0, 6,  1'b0, "out_ack2"};
    vecs[1] = '{1'b1, 0, 0, 4,  1'b0, "out_fast"};
    vecs[2] = '{1'b0, 0, 0, 3,  1'b0, "in_fast"};
    vecs[3] = '{1'b1, 8, 0, 10, 1'b1, "out_tmo_stb"};
    vecs[4] = '{1'b0, 7, 0, 10, 1'b0, "in_valid_at_tc"};
    vecs[5] = '{1'b0, 8, 0, 9,  1'b1, "in_tmo"};
    vecs[6] = '{1'b1, 7, 7, 18, 1'b0, "out_both_at_tc"};
    vecs[7] = '{1'b1, 3, 8, 14, 1'b1, "out_tmo_rel"};

    clear = 1'b1;
    cpu_req = 1'b0;
    cpu_rw = 1'b0;
    cpu_err_clr = 1'b0;
    dev_ack = 1'b0;
    dev_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_obs("reset", 0, '0);
    clear = 1'b0;
    step();
    check_obs("post_reset_idle", 0, '0);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].rw, vecs[i].d1, vecs[i].d2, 1'b0, vecs[i].name, od, oe);
      check_val({vecs[i].name, "_done_cycle"}, od, vecs[i].exp_done);
      check_val({vecs[i].name, "_err"}, int'(oe), int'(vecs[i].exp_err));
    end
    check_val("count_after_table", int'(xfer_count), 5);

    // Sticky error survives until cleared.
    check_val("sticky_held", int'(err_sticky), 1);
    cpu_err_clr = 1'b1;
    step();
    cpu_err_clr = 1'b0;
    m_sticky = 1'b0;
    check_val("sticky_cleared", int'(err_sticky), 0);

    // Requests while busy are dropped; exactly one completion.
    run_txn(1'b1, 5, 2, 1'b1, "busy_noise", od, oe);
    check_val("busy_noise_done", od, 11);

    // Leave a latched error so the clear below has something to drop.
    run_txn(1'b0, 9, 0, 1'b0, "pre_clear_err", od, oe);

    // Asynchronous clear in the middle of the output strobe phase.
    cpu_req = 1'b1;
    cpu_rw  = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    step();
    check_val("strobe_before_clear", int'(dev_strobe), 1);
    #2;
    clear = 1'b1;
    #1;
    check_obs("async_clear", 3, '0);
    @(posedge clock);
    #1;
    check_obs("clear_held", 4, '0);
    clear = 1'b0;
    m_count = 0;
    m_sticky = 1'b0;
    step();
    check_obs("after_clear_idle", 0, '0);
    run_txn(1'b1, 0, 0, 1'b0, "after_clear_txn", od, oe);
    check_val("after_clear_done", od, 4);

    // Counter wrap: count back to 15, then one more returns to 0.
    clear = 1'b1;
    #2;
    clear = 1'b0;
    m_count = 0;
    m_sticky = 1'b0;
    step();
    for (int i = 0; i < 15; i++) run_txn(1'b0, 0, 0, 1'b0, "wrap_fill", od, oe);
    check_val("count_15", int'(xfer_count), 15);
    run_txn(1'b0, 0, 0, 1'b0, "wrap_last", od, oe);
    check_val("count_wrap_0", int'(xfer_count), 0);

    // Randomised transfers against the reference timing rules.
    for (int i = 0; i < 60; i++) begin
      logic rw;
      int   d1;
      int   d2;
      rw = 1'($urandom_range(0, 1));
      d1 = int'($urandom_range(0, 10));
      d2 = int'($urandom_range(0, 10));
      run_txn(rw, d1, d2, 1'b1, "random", od, oe);
      check_val("random_done_cycle", od, done_cycle(rw, d1, d2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
